// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus: pipeline hazard flags in, register enables out.
// Handshake: none. Every signal is a level sampled within the same Clk cycle;
// the controller answers combinationally and never waits for an acknowledge.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 32
);
  // ID stage
  logic             ID_Branch;
  logic             BranchTaken;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  // EX stage
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic             ID_EX_MulDiv;
  logic [4:0]       ID_EX_rd;
  // MEM stage
  logic             EX_MEM_MemRead;
  logic             EX_MEM_MemWrite;
  logic [4:0]       EX_MEM_rd;
  logic             DMemReady;
  // Controls
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic             EX_MEM_Bubble;
  logic             MEM_WB_Bubble;
  logic             MulDivBusy;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;
  // FSM state for checkers: 0 = RUN, 1 = MULDIV
  logic             StateDbg;

  // Pipeline side: drives hazard flags, receives controls
  modport master (
    output ID_Branch, BranchTaken, ID_UsesRs, ID_UsesRt, IF_ID_rs, IF_ID_rt,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_MulDiv, ID_EX_rd,
           EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_rd, DMemReady,
    input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
           ID_EX_Bubble, EX_MEM_Bubble, MEM_WB_Bubble, MulDivBusy,
           StallCycles, FlushCount, StateDbg
  );

  // Controller side
  modport slave (
    input  ID_Branch, BranchTaken, ID_UsesRs, ID_UsesRt, IF_ID_rs, IF_ID_rt,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_MulDiv, ID_EX_rd,
           EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_rd, DMemReady,
    output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
           ID_EX_Bubble, EX_MEM_Bubble, MEM_WB_Bubble, MulDivBusy,
           StallCycles, FlushCount, StateDbg
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core: memory freeze,
// mul/div EX occupancy, load-use / branch-operand stalls, taken-branch flush,
// plus saturating stall and flush statistics.
module hazard_stall_controller #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  hazard_stall_controller_if.slave bus
);

  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;

  state_t         state, nextState;
  logic [CW-1:0]  cnt, nextCnt;
  logic [CNT_W-1:0] stallCycles, flushCount;

  logic pcWrite, ifIdWrite, idExWrite, exMemWrite;
  logic ifIdFlush, idExBubble, exMemBubble, memWbBubble;
  logic memStall, idHazard;

  // Register r is a live source operand of the ID instruction (r0 never is)
  function automatic logic regMatch(input logic [4:0] r, input logic usesRs,
                                    input logic usesRt, input logic [4:0] rs,
                                    input logic [4:0] rt);
    return (r != 5'd0) && ((usesRs && (r == rs)) || (usesRt && (r == rt)));
  endfunction

  // Hazard terms that forwarding cannot cover
  always_comb begin
    memStall = (bus.EX_MEM_MemRead || bus.EX_MEM_MemWrite) && !bus.DMemReady;
    idHazard = 1'b0;
    if (bus.ID_Branch) begin
      idHazard = (bus.ID_EX_RegWrite &&
                  regMatch(bus.ID_EX_rd, bus.ID_UsesRs, bus.ID_UsesRt,
                           bus.IF_ID_rs, bus.IF_ID_rt)) ||
                 (bus.EX_MEM_MemRead &&
                  regMatch(bus.EX_MEM_rd, bus.ID_UsesRs, bus.ID_UsesRt,
                           bus.IF_ID_rs, bus.IF_ID_rt));
    end else begin
      idHazard = bus.ID_EX_MemRead &&
                 regMatch(bus.ID_EX_rd, bus.ID_UsesRs, bus.ID_UsesRt,
                          bus.IF_ID_rs, bus.IF_ID_rt);
    end
  end

  // Priority-ordered next-state and control decode; Reset forces all zero
  always_comb begin
    nextState   = state;
    nextCnt     = cnt;
    pcWrite     = 1'b0;
    ifIdWrite   = 1'b0;
    idExWrite   = 1'b0;
    exMemWrite  = 1'b0;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    exMemBubble = 1'b0;
    memWbBubble = 1'b0;
    if (!Reset) begin
      if (memStall) begin
        // whole pipeline frozen; MEM/WB gets a NOP so WB does not repeat
        memWbBubble = 1'b1;
      end else if (state == RUN && bus.ID_EX_MulDiv) begin
        exMemWrite  = 1'b1;
        exMemBubble = 1'b1;
        nextState   = MULDIV;
        nextCnt     = CW'(MULDIV_LAT - 1);
      end else if (state == MULDIV && cnt > CW'(1)) begin
        exMemWrite  = 1'b1;
        exMemBubble = 1'b1;
        nextCnt     = cnt - CW'(1);
      end else begin
        // RUN without mul/div, or the mul/div exit cycle
        if (state == MULDIV) begin
          nextState = RUN;
          nextCnt   = '0;
        end
        if (idHazard) begin
          idExWrite   = 1'b1;
          idExBubble  = 1'b1;
          exMemWrite  = 1'b1;
        end else begin
          pcWrite    = 1'b1;
          ifIdWrite  = 1'b1;
          idExWrite  = 1'b1;
          exMemWrite = 1'b1;
          ifIdFlush  = bus.ID_Branch && bus.BranchTaken;
        end
      end
    end
  end

  // FSM state and mul/div down-counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (!pcWrite && stallCycles != '1) stallCycles <= stallCycles + CNT_W'(1);
      if (ifIdFlush && flushCount != '1) flushCount <= flushCount + CNT_W'(1);
    end
  end

  assign bus.PCWrite       = pcWrite;
  assign bus.IF_ID_Write   = ifIdWrite;
  assign bus.ID_EX_Write   = idExWrite;
  assign bus.EX_MEM_Write  = exMemWrite;
  assign bus.IF_ID_Flush   = ifIdFlush;
  assign bus.ID_EX_Bubble  = idExBubble;
  assign bus.EX_MEM_Bubble = exMemBubble;
  assign bus.MEM_WB_Bubble = memWbBubble;
  assign bus.MulDivBusy    = (state == MULDIV) && !Reset;
  assign bus.StallCycles   = stallCycles;
  assign bus.FlushCount    = flushCount;
  assign bus.StateDbg      = state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MULDIV_LAT=4, CNT_W=4 so the
// saturation point is reachable).
module tb_hazard_stall_controller;

  localparam int LAT = 4;
  localparam int CW  = 4;

  // Control vector: PCWrite IF_ID_Write ID_EX_Write EX_MEM_Write |
  //                 IF_ID_Flush ID_EX_Bubble EX_MEM_Bubble MEM_WB_Bubble | MulDivBusy
  localparam logic [8:0] ZERO_V   = 9'b0000_0000_0;
  localparam logic [8:0] RUN_V    = 9'b1111_0000_0;
  localparam logic [8:0] IDSTL_V  = 9'b0011_0100_0;
  localparam logic [8:0] FLUSH_V  = 9'b1111_1000_0;
  localparam logic [8:0] MDSTART  = 9'b0001_0010_0;
  localparam logic [8:0] MDCONT   = 9'b0001_0010_1;
  localparam logic [8:0] MDEXIT   = 9'b1111_0000_1;
  localparam logic [8:0] FRZ_V    = 9'b0000_0001_0;
  localparam logic [8:0] FRZBUSY  = 9'b0000_0001_1;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;
  logic [8:0] exp_q[$];

  hazard_stall_controller_if #(.CNT_W(CW)) bus ();

  hazard_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [8:0] obsCtl;
  assign obsCtl = {bus.PCWrite, bus.IF_ID_Write, bus.ID_EX_Write, bus.EX_MEM_Write,
                   bus.IF_ID_Flush, bus.ID_EX_Bubble, bus.EX_MEM_Bubble,
                   bus.MEM_WB_Bubble, bus.MulDivBusy};

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  // ---------------- driver tasks ----------------
  task automatic idleInputs();
    bus.ID_Branch = 0; bus.BranchTaken = 0; bus.ID_UsesRs = 0; bus.ID_UsesRt = 0;
    bus.IF_ID_rs = 0; bus.IF_ID_rt = 0;
    bus.ID_EX_MemRead = 0; bus.ID_EX_RegWrite = 0; bus.ID_EX_MulDiv = 0; bus.ID_EX_rd = 0;
    bus.EX_MEM_MemRead = 0; bus.EX_MEM_MemWrite = 0; bus.EX_MEM_rd = 0; bus.DMemReady = 1;
  endtask

  // scoreboard pop/compare against the current outputs
  task automatic compareCtl(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (obsCtl === e) else begin
        failures++;
        $error("FAIL %s ctl got=%b exp=%b", tag, obsCtl, e);
      end
    end
  endtask

  // one cycle: push expectation, compare at negedge, advance past posedge
  task automatic stepCheck(input string tag, input logic [8:0] e);
    exp_q.push_back(e);
    @(negedge Clk);
    compareCtl(tag);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkCnt(input string tag, input int stallExp, input int flushExp);
    checks++;
    assert (int'(bus.StallCycles) === stallExp) else begin
      failures++;
      $error("FAIL %s StallCycles got=%0d exp=%0d", tag, bus.StallCycles, stallExp);
    end
    checks++;
    assert (int'(bus.FlushCount) === flushExp) else begin
      failures++;
      $error("FAIL %s FlushCount got=%0d exp=%0d", tag, bus.FlushCount, flushExp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    failures = 0;
    idleInputs();
    Reset = 1'b1;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) stepCheck("reset_hold", ZERO_V);
    checkCnt("reset_cnt", 0, 0);

    // release, no hazards
    Reset = 1'b0;
    stepCheck("idle0", RUN_V);
    stepCheck("idle1", RUN_V);
    checkCnt("idle_cnt", 0, 0);

    // lw $t0 in EX, add in ID reads $t0
    bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_rd = 8;
    bus.ID_UsesRs = 1; bus.IF_ID_rs = 8;
    stepCheck("loaduse", IDSTL_V);
    bus.ID_EX_MemRead = 0; bus.ID_EX_RegWrite = 0; bus.ID_EX_rd = 0;
    bus.EX_MEM_MemRead = 1; bus.EX_MEM_rd = 8;
    stepCheck("loaduse_go", RUN_V);
    checkCnt("loaduse_cnt", 1, 0);

    // lw $t0 then beq $t0 (taken): two stalls, then flush
    idleInputs();
    bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_rd = 8;
    bus.ID_Branch = 1; bus.BranchTaken = 1; bus.ID_UsesRs = 1; bus.IF_ID_rs = 8;
    stepCheck("lbr_idex", IDSTL_V);
    bus.ID_EX_MemRead = 0; bus.ID_EX_RegWrite = 0; bus.ID_EX_rd = 0;
    bus.EX_MEM_MemRead = 1; bus.EX_MEM_rd = 8;
    stepCheck("lbr_exmem", IDSTL_V);
    bus.EX_MEM_MemRead = 0; bus.EX_MEM_rd = 0;
    stepCheck("lbr_flush", FLUSH_V);
    checkCnt("lbr_cnt", 3, 1);

    // ALU result in EX feeding a branch via rt: 1 stall
    idleInputs();
    bus.ID_EX_RegWrite = 1; bus.ID_EX_rd = 9;
    bus.ID_Branch = 1; bus.ID_UsesRt = 1; bus.IF_ID_rt = 9;
    stepCheck("alubr", IDSTL_V);
    bus.ID_EX_RegWrite = 0; bus.ID_EX_rd = 0;
    stepCheck("alubr_go", RUN_V);

    // load to $zero never stalls
    idleInputs();
    bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_rd = 0;
    bus.ID_UsesRs = 1; bus.IF_ID_rs = 0;
    stepCheck("r0_nostall", RUN_V);
    checkCnt("alubr_cnt", 4, 1);

    // mul in EX at T
    idleInputs();
    bus.ID_EX_MulDiv = 1;
    stepCheck("mul_T0", MDSTART);
    stepCheck("mul_T1", MDCONT);
    stepCheck("mul_T2", MDCONT);
    stepCheck("mul_T3", MDEXIT);
    bus.ID_EX_MulDiv = 0;
    stepCheck("mul_after", RUN_V);
    checkCnt("mul_cnt", 7, 1);

    // mul with a 2-cycle memory freeze at T+1
    bus.ID_EX_MulDiv = 1;
    stepCheck("mfz_T0", MDSTART);
    bus.EX_MEM_MemWrite = 1; bus.DMemReady = 0;
    stepCheck("mfz_T1", FRZBUSY);
    stepCheck("mfz_T2", FRZBUSY);
    bus.EX_MEM_MemWrite = 0; bus.DMemReady = 1;
    stepCheck("mfz_T3", MDCONT);
    stepCheck("mfz_T4", MDCONT);
    stepCheck("mfz_T5", MDEXIT);
    bus.ID_EX_MulDiv = 0;
    stepCheck("mfz_after", RUN_V);
    checkCnt("mfz_cnt", 12, 1);

    // reset pulsed at T+1 of a mul
    bus.ID_EX_MulDiv = 1;
    stepCheck("mrst_T0", MDSTART);
    #1;
    Reset = 1'b1;
    #1;
    exp_q.push_back(ZERO_V);
    compareCtl("mrst_async");
    checkCnt("mrst_cnt", 0, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    bus.ID_EX_MulDiv = 0;
    stepCheck("mrst_rel0", RUN_V);
    stepCheck("mrst_rel1", RUN_V);
    checkCnt("mrst_relcnt", 0, 0);

    // long freeze saturates StallCycles at 15
    bus.EX_MEM_MemRead = 1; bus.DMemReady = 0;
    for (int i = 0; i < 18; i++) stepCheck("sat_frz", FRZ_V);
    checkCnt("sat_cnt", 15, 0);
    idleInputs();
    stepCheck("sat_go", RUN_V);
    checkCnt("sat_hold", 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
